// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port (m_*) between the fetch channel (PC/Inst_*) and the load/store channel (Address/Mem*/Read_data*), with grant and conflict counters
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                Inst_Req_Valid,
  output logic                Inst_Req_Ready,
  output logic [DATA_W-1:0]   Instruction,
  output logic                Inst_Valid,
  input  logic                Inst_Ready,
  input  logic [ADDR_W-1:0]   Address,
  input  logic                MemWrite,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_strb,
  input  logic                MemRead,
  output logic                Mem_Req_Ready,
  output logic [DATA_W-1:0]   Read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ready,
  output logic [ADDR_W-1:0]   m_Address,
  output logic                m_MemRead,
  output logic                m_MemWrite,
  output logic [DATA_W-1:0]   m_Write_data,
  output logic [DATA_W/8-1:0] m_Write_strb,
  input  logic                m_Req_Ready,
  input  logic [DATA_W-1:0]   m_Read_data,
  input  logic                m_Read_data_Valid,
  output logic                m_Read_data_Ready,
  output logic [31:0]         inst_grant_cnt,
  output logic [31:0]         data_grant_cnt,
  output logic [31:0]         conflict_cnt
);
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    I_REQ  = 5'b00010,
    I_RESP = 5'b00100,
    D_REQ  = 5'b01000,
    D_RESP = 5'b10000
  } state_t;
  state_t      r_state;
  logic        r_last_d;
  logic        r_grant_d;
  logic [31:0] r_inst_cnt;
  logic [31:0] r_data_cnt;
  logic [31:0] r_conf_cnt;
  logic        w_d_req;
  logic        w_pick_d;
  logic        w_ireq;
  logic        w_iresp;
  logic        w_dreq;
  logic        w_dresp;
  logic        w_fwd;
  assign w_d_req  = MemRead | MemWrite;
  assign w_pick_d = w_d_req & (~Inst_Req_Valid | ~r_last_d);
  assign w_ireq   = ~rst & (r_state == I_REQ);
  assign w_iresp  = ~rst & (r_state == I_RESP);
  assign w_dreq   = ~rst & (r_state == D_REQ);
  assign w_dresp  = ~rst & (r_state == D_RESP);
  assign w_fwd    = w_ireq | w_dreq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_grant_d  <= 1'b0;
      r_inst_cnt <= '0;
      r_data_cnt <= '0;
      r_conf_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (Inst_Req_Valid | w_d_req) begin
          r_state   <= w_pick_d ? D_REQ : I_REQ;
          r_last_d  <= w_pick_d;
          r_grant_d <= w_pick_d;
          if (w_pick_d) r_data_cnt <= r_data_cnt + 32'd1;
          else r_inst_cnt <= r_inst_cnt + 32'd1;
          if (Inst_Req_Valid & w_d_req) r_conf_cnt <= r_conf_cnt + 32'd1;
        end
        I_REQ:  r_state <= !Inst_Req_Valid ? IDLE : m_Req_Ready ? I_RESP : I_REQ;
        I_RESP: if (m_Read_data_Valid & Inst_Ready) r_state <= IDLE;
        D_REQ:  r_state <= !w_d_req ? IDLE : !m_Req_Ready ? D_REQ : MemWrite ? IDLE : D_RESP;
        D_RESP: if (m_Read_data_Valid & Read_data_Ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign m_Address         = w_fwd ? (r_grant_d ? Address : PC) : '0;
  assign m_MemRead         = w_ireq ? Inst_Req_Valid : w_dreq & MemRead & ~MemWrite;
  assign m_MemWrite        = w_dreq & MemWrite;
  assign m_Write_data      = w_dreq ? Write_data : '0;
  assign m_Write_strb      = w_dreq ? Write_strb : '0;
  assign Inst_Req_Ready    = w_ireq & m_Req_Ready;
  assign Mem_Req_Ready     = w_dreq & m_Req_Ready;
  assign Instruction       = w_iresp ? m_Read_data : '0;
  assign Inst_Valid        = w_iresp & m_Read_data_Valid;
  assign Read_data         = w_dresp ? m_Read_data : '0;
  assign Read_data_Valid   = w_dresp & m_Read_data_Valid;
  assign m_Read_data_Ready = w_iresp ? Inst_Ready : w_dresp & Read_data_Ready;
  assign inst_grant_cnt    = rst ? '0 : r_inst_cnt;
  assign data_grant_cnt    = rst ? '0 : r_data_cnt;
  assign conflict_cnt      = rst ? '0 : r_conf_cnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a transaction-level round-robin reference model
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  logic clk = 0;
  logic rst = 1;
  logic [AW-1:0] PC = '0;
  logic [AW-1:0] Address = '0;
  logic Inst_Req_Valid = 0;
  logic Inst_Ready = 0;
  logic MemWrite = 0;
  logic MemRead = 0;
  logic Read_data_Ready = 0;
  logic [DW-1:0] Write_data = '0;
  logic [SW-1:0] Write_strb = '0;
  logic m_Req_Ready = 0;
  logic m_Read_data_Valid = 0;
  logic [DW-1:0] m_Read_data = '0;
  logic Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid;
  logic m_MemRead, m_MemWrite, m_Read_data_Ready;
  logic [DW-1:0] Instruction, Read_data, m_Write_data;
  logic [AW-1:0] m_Address;
  logic [SW-1:0] m_Write_strb;
  logic [31:0] inst_grant_cnt, data_grant_cnt, conflict_cnt;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .m_Address(m_Address), .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite),
    .m_Write_data(m_Write_data), .m_Write_strb(m_Write_strb), .m_Req_Ready(m_Req_Ready),
    .m_Read_data(m_Read_data), .m_Read_data_Valid(m_Read_data_Valid),
    .m_Read_data_Ready(m_Read_data_Ready),
    .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          rd;
    logic          wr;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } mtx_t;

  int vectors = 0;
  int errors = 0;
  mtx_t exp_mem[$];
  logic [DW-1:0] exp_inst[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] preload[logic [AW-1:0]];
  int m_inst = 0;
  int m_data = 0;
  int m_conf = 0;
  bit m_last_d = 1;
  int mem_mode = 1;
  bit cpu_fast = 1;
  bit mem_pend = 0;
  logic [DW-1:0] mem_pdata = '0;
  bit prev_p = 0;
  logic [AW+1:0] prev_v = '0;
  mtx_t mon_e;

  function automatic logic [DW-1:0] rdmem(input logic [AW-1:0] a);
    return preload.exists(a) ? preload[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [63:0] v);
    vectors++;
    errors++;
    $display("FAIL %s: got %0h expected nothing (no pending expectation or bound expired)", nm, v);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {Inst_Req_Ready, Instruction, Inst_Valid, Mem_Req_Ready, Read_data, Read_data_Valid,
             m_Address, m_MemRead, m_MemWrite, m_Write_data, m_Write_strb, m_Read_data_Ready,
             inst_grant_cnt, data_grant_cnt, conflict_cnt}, '0);
  endtask

  task automatic chk_cnt(input string nm);
    @(negedge clk);
    chk({nm, "_inst_cnt"}, inst_grant_cnt, m_inst);
    chk({nm, "_data_cnt"}, data_grant_cnt, m_data);
    chk({nm, "_conf_cnt"}, conflict_cnt, m_conf);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    Inst_Ready = cpu_fast | ($urandom_range(0, 1) == 1);
    Read_data_Ready = cpu_fast | ($urandom_range(0, 1) == 1);
  end

  // memory model: random accept/response delays, spurious valid pulses while nothing is pending
  initial forever begin
    @(negedge clk);
    if (rst) mem_pend = 0;
    else begin
      if (m_Read_data_Valid && m_Read_data_Ready) mem_pend = 0;
      if (m_MemRead && m_Req_Ready) begin
        mem_pend = 1;
        mem_pdata = rdmem(m_Address);
      end
    end
    @(posedge clk); #1;
    case (mem_mode)
      1: begin m_Req_Ready = 1; m_Read_data_Valid = mem_pend; m_Read_data = mem_pend ? mem_pdata : '0; end
      2: begin m_Req_Ready = 0; m_Read_data_Valid = 1; m_Read_data = $urandom; end
      3: begin m_Req_Ready = 1; m_Read_data_Valid = 0; m_Read_data = $urandom; end
      default: begin
        m_Req_Ready = $urandom_range(0, 2) != 0;
        m_Read_data_Valid = mem_pend ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
        m_Read_data = mem_pend ? mem_pdata : $urandom;
      end
    endcase
  end

  // monitor: pops the scoreboard whenever the DUT presents a request or response
  initial forever begin
    @(negedge clk);
    if (rst) prev_p = 0;
    else begin
      chk("exclusive", {Inst_Req_Ready & Mem_Req_Ready, Inst_Valid & Read_data_Valid, m_MemRead & m_MemWrite}, '0);
      if (prev_p && (Inst_Req_Valid || MemRead || MemWrite)) chk("m_hold", {m_Address, m_MemRead, m_MemWrite}, prev_v);
      prev_p = (m_MemRead | m_MemWrite) & ~m_Req_Ready;
      prev_v = {m_Address, m_MemRead, m_MemWrite};
      if ((m_MemRead || m_MemWrite) && m_Req_Ready) begin
        if (exp_mem.size() == 0) bad("mem_unexpected", {m_Address, m_MemRead, m_MemWrite});
        else begin
          mon_e = exp_mem.pop_front();
          chk("mem_req", {m_Address, m_MemRead, m_MemWrite, m_Write_data, m_Write_strb}, mon_e);
        end
      end
      if (Inst_Valid) begin
        if (exp_inst.size() == 0) bad("inst_unexpected", Instruction);
        else if (Inst_Ready) chk("inst_data", Instruction, exp_inst.pop_front());
      end
      if (Read_data_Valid) begin
        if (exp_rd.size() == 0) bad("load_unexpected", Read_data);
        else if (Read_data_Ready) chk("load_data", Read_data, exp_rd.pop_front());
      end
    end
  end

  task automatic fetch(input logic [AW-1:0] pc, output int rq, output int rs);
    int n = 0;
    rq = 0;
    rs = 0;
    PC = pc;
    Inst_Req_Valid = 1;
    while (1) begin
      @(negedge clk); n++;
      if (Inst_Req_Ready) break;
      if (n > 300) begin bad("fetch_req_timeout", n); Inst_Req_Valid = 0; return; end
    end
    rq = n;
    @(posedge clk); #1;
    Inst_Req_Valid = 0;
    PC = $urandom;
    while (1) begin
      @(negedge clk); n++;
      if (Inst_Valid && Inst_Ready) break;
      if (n > 600) begin bad("fetch_rsp_timeout", n); return; end
    end
    rs = n;
    @(posedge clk); #1;
  endtask

  task automatic data_op(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, output int rq, output int rs);
    int n = 0;
    rq = 0;
    rs = 0;
    Address = a; MemRead = rd; MemWrite = wr; Write_data = wd; Write_strb = st;
    while (1) begin
      @(negedge clk); n++;
      if (Mem_Req_Ready) break;
      if (n > 300) begin bad("data_req_timeout", n); MemRead = 0; MemWrite = 0; return; end
    end
    rq = n;
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0; Address = $urandom; Write_data = $urandom;
    if (rd && !wr) begin
      while (1) begin
        @(negedge clk); n++;
        if (Read_data_Valid && Read_data_Ready) break;
        if (n > 600) begin bad("data_rsp_timeout", n); return; end
      end
      rs = n;
      @(posedge clk); #1;
    end else rs = rq;
  endtask

  // one round: requests issued together from IDLE; the model predicts grant order and responses
  task automatic round(input bit di, input bit dd, input logic [AW-1:0] pc, input logic [AW-1:0] a,
                       input bit rd, input bit wr, input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       output int irq, output int irs, output int drq, output int drs);
    mtx_t ti, td;
    bit first_d;
    ti = '{a: pc, rd: 1'b1, wr: 1'b0, d: '0, s: '0};
    td = '{a: a, rd: rd & ~wr, wr: wr, d: wd, s: st};
    first_d = dd && !(di && m_last_d);
    if (first_d) begin
      exp_mem.push_back(td);
      if (di) exp_mem.push_back(ti);
    end else begin
      if (di) exp_mem.push_back(ti);
      if (dd) exp_mem.push_back(td);
    end
    if (di) begin m_inst++; exp_inst.push_back(rdmem(pc)); end
    if (dd) begin m_data++; if (rd && !wr) exp_rd.push_back(rdmem(a)); end
    if (di && dd) m_conf++;
    m_last_d = (di && dd) ? !first_d : dd;
    irq = 0; irs = 0; drq = 0; drs = 0;
    fork
      begin if (di) fetch(pc, irq, irs); end
      begin if (dd) data_op(a, rd, wr, wd, st, drq, drs); end
    join
  endtask

  task automatic rand_round();
    int k, op, a, b, c, d;
    k = $urandom_range(1, 3);
    op = $urandom_range(0, 2);
    round(k[0], k[1], $urandom, $urandom, op != 1, op != 0, $urandom, 4'($urandom), a, b, c, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int irq, irs, drq, drs, n;
    preload[32'h100] = 32'h2402_0005;
    PC = 5; Inst_Req_Valid = 1; MemRead = 1; MemWrite = 1; Address = 7; Write_data = '1; Write_strb = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst_high");
    @(posedge clk); #1;
    rst = 0; Inst_Req_Valid = 0; MemRead = 0; MemWrite = 0;
    @(negedge clk);
    chk_zero("rst_after");
    @(posedge clk); #1;
    round(1, 0, 32'h100, '0, 0, 0, '0, '0, irq, irs, drq, drs);
    chk("fetch_ready_cycle", irq, 2);
    chk("fetch_valid_cycle", irs, 3);
    chk_cnt("fetch_only");
    round(0, 1, '0, 32'h2000, 0, 1, 32'hDEAD_BEEF, 4'hF, irq, irs, drq, drs);
    chk("store_ready_cycle", drq, 2);
    chk_cnt("store_only");
    round(1, 1, 32'h104, 32'h3000, 1, 0, $urandom, 4'h0, irq, irs, drq, drs);
    chk("conflict_inst_done", irs, 3);
    chk("conflict_load_ready", drq, 5);
    chk("conflict_load_done", drs, 6);
    chk_cnt("conflict");
    mem_mode = 0;
    cpu_fast = 0;
    repeat (4) round(1, 1, $urandom, $urandom, 1, $urandom_range(0, 1) == 1, $urandom, 4'($urandom), irq, irs, drq, drs);
    chk_cnt("alternate");
    repeat (40) rand_round();
    chk_cnt("random");
    mem_mode = 2;
    PC = $urandom; Inst_Req_Valid = 1; m_inst++; m_last_d = 0;
    repeat (4) @(posedge clk); #1;
    Inst_Req_Valid = 0;
    repeat (2) @(posedge clk); #1;
    chk_cnt("fetch_abort");
    Address = $urandom; MemRead = 1; m_data++; m_last_d = 1;
    repeat (3) @(posedge clk); #1;
    MemRead = 0;
    repeat (2) @(posedge clk); #1;
    chk_cnt("data_abort");
    mem_mode = 0;
    repeat (6) rand_round();
    chk_cnt("after_abort");
    mem_mode = 3;
    cpu_fast = 1;
    @(posedge clk); #1;
    PC = 32'h200; Inst_Req_Valid = 1;
    exp_mem.push_back('{a: 32'h200, rd: 1'b1, wr: 1'b0, d: '0, s: '0});
    n = 0;
    do begin @(negedge clk); n++; end while (!Inst_Req_Ready && n < 50);
    if (!Inst_Req_Ready) bad("rst_test_req_timeout", n);
    @(posedge clk); #1;
    Inst_Req_Valid = 0;
    @(negedge clk);
    chk("in_inst_resp", m_Read_data_Ready, 1);
    @(posedge clk); #1;
    rst = 1; m_inst = 0; m_data = 0; m_conf = 0; m_last_d = 1;
    @(negedge clk);
    chk_zero("rst_mid");
    @(posedge clk); #1;
    rst = 0; mem_mode = 2;
    @(negedge clk);
    chk_zero("rst_mid_after");
    repeat (4) begin
      @(negedge clk);
      chk("no_fwd_after_rst", {Inst_Valid, Read_data_Valid, Instruction}, '0);
    end
    @(posedge clk); #1;
    chk_cnt("post_rst");
    mem_mode = 0;
    round(1, 1, $urandom, $urandom, 1, 0, $urandom, 4'($urandom), irq, irs, drq, drs);
    chk("rst_inst_first", irs < drq, 1);
    chk_cnt("post_rst_round");
    chk("queues_empty", exp_mem.size() + exp_inst.size() + exp_rd.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
